// File: rtl/spi_pkg.sv
`default_nettype none
// =============================================================================
// Module   : spi_pkg
// Purpose  : Shared state encoding and default geometry for the SPI control FSM.
// Revision : 1.0
// =============================================================================
package spi_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        GET          = 3'd0,
        GOT          = 3'd1,
        READ_WAIT    = 3'd2,
        READ_LOAD    = 3'd3,
        READ_SHIFT   = 3'd4,
        WRITE_SHIFT  = 3'd5,
        WRITE_COMMIT = 3'd6,
        DONE         = 3'd7
    } spi_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ctrl_fsm_if.sv
`default_nettype none
// =============================================================================
// Module   : spi_ctrl_fsm_if
// Purpose  : Chip-select/header inputs and datapath strobes of the SPI control FSM.
// Revision : 1.0
// =============================================================================
interface spi_ctrl_fsm_if;

    logic cs;
    logic rw;
    logic addr_we;
    logic dm_we;
    logic sr_we;
    logic miso_bufe;
    logic addr_inc;

    modport master (
        output cs,
        output rw,
        input  addr_we,
        input  dm_we,
        input  sr_we,
        input  miso_bufe,
        input  addr_inc
    );

    modport slave (
        input  cs,
        input  rw,
        output addr_we,
        output dm_we,
        output sr_we,
        output miso_bufe,
        output addr_inc
    );

endinterface
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// =============================================================================
// Module   : spi_bit_counter
// Purpose  : Edge counter with clear, enable and terminal-count compare.
// Revision : 1.0
// =============================================================================
module spi_bit_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             sclk,
    input  wire logic             reset,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    input  wire logic [WIDTH-1:0] tc_val_i,
    output logic                  tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule
`default_nettype wire

// File: rtl/spi_ctrl_fsm.sv
`default_nettype none
// =============================================================================
// Module   : spi_ctrl_fsm
// Purpose  : Moore FSM decoding an SPI header and sequencing read/write strobes.
// Revision : 1.0
// =============================================================================
module spi_ctrl_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BURST_EN = 0
) (
    input  wire logic     sclk,
    input  wire logic     reset,
    spi_ctrl_fsm_if.slave bus
);

    localparam int H  = ADDR_W + 1;
    localparam int CW = $clog2(max_int(H, DATA_W) + 1);

    spi_state_e    state_q;
    spi_state_e    state_d;
    logic          inc_q;
    logic          inc_d;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_tc;
    logic [CW-1:0] tc_val;

    spi_bit_counter #(
        .WIDTH (CW)
    ) u_bit_counter (
        .sclk     (sclk),
        .reset    (reset),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .tc_val_i (tc_val),
        .tc_o     (cnt_tc)
    );

    // Counter restarts on every state change so each state sees edges from zero.
    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        tc_val  = (state_q == GET) ? CW'(H - 1) : CW'(DATA_W - 1);
        if (bus.cs) begin
            state_d = GET;
        end else begin
            case (state_q)
                GET:          if (cnt_tc) state_d = GOT;
                GOT:          state_d = bus.rw ? READ_WAIT : WRITE_SHIFT;
                READ_WAIT:    state_d = READ_LOAD;
                READ_LOAD:    state_d = READ_SHIFT;
                READ_SHIFT: begin
                    if (cnt_tc) begin
                        if (BURST_EN != 0) begin
                            state_d = READ_WAIT;
                            inc_d   = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                WRITE_SHIFT:  if (cnt_tc) state_d = WRITE_COMMIT;
                WRITE_COMMIT: begin
                    if (BURST_EN != 0) begin
                        state_d = WRITE_SHIFT;
                        inc_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE:         state_d = DONE;
                default:      state_d = GET;
            endcase
        end
        cnt_clr = bus.cs || (state_d != state_q);
        cnt_en  = (state_q == GET) || (state_q == READ_SHIFT) || (state_q == WRITE_SHIFT);
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q <= GET;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
        end
    end

    assign bus.addr_we   = (state_q == GOT);
    assign bus.sr_we     = (state_q == READ_LOAD);
    assign bus.miso_bufe = (state_q == READ_SHIFT);
    assign bus.dm_we     = (state_q == WRITE_COMMIT);
    assign bus.addr_inc  = inc_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl_fsm.sv
`default_nettype none
// =============================================================================
// Module   : tb_spi_ctrl_fsm
// Purpose  : Randomized check of single-word and burst instances against a frame model.
// Revision : 1.0
// =============================================================================
module tb_spi_ctrl_fsm;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int H  = AW + 1;

    // Output vector bit order: {addr_we, dm_we, sr_we, miso_bufe, addr_inc}
    localparam logic [4:0] C_A = 5'b10000;
    localparam logic [4:0] C_D = 5'b01000;
    localparam logic [4:0] C_S = 5'b00100;
    localparam logic [4:0] C_M = 5'b00010;
    localparam logic [4:0] C_I = 5'b00001;

    logic sclk = 1'b0;
    logic reset;

    spi_ctrl_fsm_if if0 ();
    spi_ctrl_fsm_if if1 ();

    spi_ctrl_fsm #(.ADDR_W(AW), .DATA_W(DW), .BURST_EN(0)) dut0 (
        .sclk  (sclk),
        .reset (reset),
        .bus   (if0)
    );

    spi_ctrl_fsm #(.ADDR_W(AW), .DATA_W(DW), .BURST_EN(1)) dut1 (
        .sclk  (sclk),
        .reset (reset),
        .bus   (if1)
    );

    always #5 sclk = ~sclk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   k        = 0;
    logic frame_rw = 1'b0;

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Expected strobes after the kk-th cs-low edge of a frame.
    function automatic logic [4:0] model(input int kk, input logic r, input bit burst);
        int m;
        int per;
        int w;
        int p;
        if (kk < H)  return 5'b0;
        if (kk == H) return C_A;
        m   = kk - H - 1;
        per = r ? DW + 2 : DW + 1;
        w   = m / per;
        p   = m % per;
        if (!burst && w > 0) return 5'b0;
        if (p == 0) return (w > 0) ? C_I : 5'b0;
        if (r) return (p == 1) ? C_S : C_M;
        return (p == DW) ? C_D : 5'b0;
    endfunction

    task automatic tick(input logic c, input logic r, input logic rs, input string tag);
        @(negedge sclk);
        if0.cs = c;
        if1.cs = c;
        if0.rw = r;
        if1.rw = r;
        reset  = rs;
        @(posedge sclk);
        if (rs || c) begin
            k = 0;
        end else begin
            k++;
            if (k == H + 1) frame_rw = r;
        end
        #1;
        check_eq($sformatf("%s/single k=%0d", tag, k),
                 {if0.addr_we, if0.dm_we, if0.sr_we, if0.miso_bufe, if0.addr_inc},
                 model(k, frame_rw, 1'b0));
        check_eq($sformatf("%s/burst k=%0d", tag, k),
                 {if1.addr_we, if1.dm_we, if1.sr_we, if1.miso_bufe, if1.addr_inc},
                 model(k, frame_rw, 1'b1));
    endtask

    // mode 0 = write, 1 = read, 2 = random rw every edge
    task automatic frame(input int len, input int mode, input string tag);
        logic r;
        for (int i = 0; i < len; i++) begin
            r = (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode);
            tick(1'b0, r, 1'b0, tag);
        end
    endtask

    initial begin
        if0.cs = 1'b1;
        if1.cs = 1'b1;
        if0.rw = 1'b0;
        if1.rw = 1'b0;
        reset  = 1'b1;

        tick(1'b1, 1'b0, 1'b1, "reset");
        tick(1'b0, 1'b0, 1'b1, "reset_cs_low");
        tick(1'b1, 1'b0, 1'b0, "idle");

        frame(40, 0, "write");
        tick(1'b1, 1'b0, 1'b0, "idle");
        frame(42, 1, "read");
        tick(1'b1, 1'b0, 1'b0, "idle");

        frame(14, 1, "abort_read");
        tick(1'b1, 1'b1, 1'b0, "abort");
        frame(20, 0, "after_abort");
        tick(1'b1, 1'b0, 1'b0, "idle");

        frame(12, 0, "mid_write");
        tick(1'b0, 1'b0, 1'b1, "reset_mid");
        frame(19, 0, "fresh_write");
        tick(1'b1, 1'b0, 1'b0, "idle");

        frame(30, 2, "rw_noise");
        tick(1'b1, 1'b0, 1'b0, "idle");

        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 19) == 0) tick(1'b0, 1'b0, 1'b1, "rand_reset");
            frame($urandom_range(1, 50), 2, "rand");
            for (int j = 0; j < $urandom_range(1, 3); j++) begin
                tick(1'b1, logic'($urandom_range(0, 1)), 1'b0, "rand_idle");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
